// File: rtl/song_pkg.sv
// song_pkg: song table bounds, rest tone and scheduler state encoding shared by
// the song scheduler and its arbiter.
package song_pkg;

   localparam logic [3:0] TONE_REST = 4'd0;

   typedef enum logic [2:0] {IDLE, FETCH, LATCH, PLAY, HOLD} state_t;

   // Song table: 0 = 0..20 (background), 1 = 21..27, 2 = 28..33, 3 = 34..39.
   function automatic logic [7:0] song_start(input logic [3:0] s);
      return s == 4'd1 ? 8'd21 : s == 4'd2 ? 8'd28 : s == 4'd3 ? 8'd34 : 8'd0;
   endfunction

   function automatic logic [7:0] song_end(input logic [3:0] s);
      return s == 4'd1 ? 8'd27 : s == 4'd2 ? 8'd33 : s == 4'd3 ? 8'd39 : 8'd20;
   endfunction

endpackage

// File: rtl/song_req_arbiter.sv
// song_req_arbiter: picks the highest pending song (or background music) and
// flags when it should displace the song currently being sequenced.
module song_req_arbiter #(
   parameter int NUM_SONGS = 4,
   parameter int SW = 2
) (
   input  logic [NUM_SONGS-1:0] pending,
   input  logic                 music_en,
   input  logic [SW-1:0]        active_song,
   output logic [SW-1:0]        sel,
   output logic                 sel_valid,
   output logic                 preempt
);

   always_comb begin
      sel = '0;
      for (int i = 1; i < NUM_SONGS; i++)
         if (pending[i]) sel = SW'(i);
      sel_valid = |pending || music_en;
      // Equal index means the active effect was re-requested and restarts.
      preempt = |pending && sel >= active_song;
   end

endmodule

// File: rtl/song_scheduler.sv
// song_scheduler: sequences the shared song ROM between the looping background
// song and prioritised one-shot effects, feeding the timer and tone generator.
module song_scheduler
   import song_pkg::*;
#(
   parameter int NUM_SONGS = 4,
   parameter int ADDR_W = 8,
   localparam int SW = (NUM_SONGS > 1) ? $clog2(NUM_SONGS) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 music_en,
   input  logic [NUM_SONGS-2:0] sfx_req,
   input  logic                 pause,
   input  logic                 note_change,
   output logic [ADDR_W-1:0]    rom_addr,
   input  logic [7:0]           rom_data,
   output logic [3:0]           dur,
   output logic [3:0]           tone,
   output logic                 note_load,
   output logic [SW-1:0]        active_song,
   output logic                 busy,
   output logic                 sfx_done
);

   state_t                state;
   logic [NUM_SONGS-1:0]  pending;
   logic [NUM_SONGS-1:0]  clr;
   logic [ADDR_W-1:0]     resume_addr;
   logic [SW-1:0]         sel;
   logic                  sel_valid;
   logic                  preempt;
   logic                  run;
   logic                  jump;
   logic                  stop;

   song_req_arbiter #(.NUM_SONGS(NUM_SONGS), .SW(SW)) u_arb (
      .pending(pending),
      .music_en(music_en),
      .active_song(active_song),
      .sel(sel),
      .sel_valid(sel_valid),
      .preempt(preempt)
   );

   // A paused note is frozen, so preemption only acts on running states.
   assign run  = state == FETCH || state == LATCH || (state == PLAY && !pause);
   assign jump = (state == IDLE && sel_valid) || (run && preempt);
   assign stop = run && active_song == '0 && !music_en;
   assign clr  = jump ? NUM_SONGS'(1) << sel : '0;
   assign busy = state != IDLE;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         rom_addr    <= ADDR_W'(song_start(4'd0));
         resume_addr <= ADDR_W'(song_start(4'd0));
         dur         <= '0;
         tone        <= TONE_REST;
         note_load   <= 1'b0;
         active_song <= '0;
         sfx_done    <= 1'b0;
         pending     <= '0;
      end else begin
         note_load <= 1'b0;
         sfx_done  <= 1'b0;
         pending   <= (pending & ~clr) | {sfx_req, 1'b0};
         if (jump) begin
            rom_addr    <= sel == '0 ? resume_addr : ADDR_W'(song_start(4'(sel)));
            active_song <= sel;
            state       <= FETCH;
            // Saving the current address replays the interrupted note later.
            if (state != IDLE && active_song == '0) resume_addr <= rom_addr;
         end else if (stop) begin
            state       <= IDLE;
            tone        <= TONE_REST;
            resume_addr <= ADDR_W'(song_start(4'd0));
         end else begin
            case (state)
               IDLE:  tone <= TONE_REST;
               FETCH: state <= LATCH;
               LATCH: begin
                  dur       <= rom_data[7:4];
                  tone      <= rom_data[3:0];
                  note_load <= 1'b1;
                  state     <= PLAY;
               end
               PLAY: begin
                  if (pause) begin
                     state <= HOLD;
                     tone  <= TONE_REST;
                  end else if (note_change) begin
                     if (rom_addr != ADDR_W'(song_end(4'(active_song)))) begin
                        rom_addr <= rom_addr + ADDR_W'(1);
                        state    <= FETCH;
                     end else if (active_song == '0) begin
                        rom_addr <= ADDR_W'(song_start(4'd0));
                        state    <= FETCH;
                     end else begin
                        sfx_done <= 1'b1;
                        tone     <= TONE_REST;
                        state    <= IDLE;
                     end
                  end
               end
               HOLD:    if (!pause) state <= LATCH;
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_song_scheduler.sv
// tb_song_scheduler: directed scenarios over a randomly filled song ROM; each
// loaded note is checked against the song table walk and the ROM contents.
module tb_song_scheduler;

   logic       clk = 1'b0;
   logic       rst;
   logic       music_en;
   logic [2:0] sfx_req;
   logic       pause;
   logic       note_change;
   logic [7:0] rom_addr;
   logic [7:0] rom_data;
   logic [3:0] dur;
   logic [3:0] tone;
   logic       note_load;
   logic [1:0] active_song;
   logic       busy;
   logic       sfx_done;

   logic [7:0] rom [256];
   int s_start [4] = '{0, 21, 28, 34};
   int s_end   [4] = '{20, 27, 33, 39};
   int total = 0;
   int bad = 0;
   int k;

   song_scheduler #(.NUM_SONGS(4), .ADDR_W(8)) dut (
      .clk(clk),
      .rst(rst),
      .music_en(music_en),
      .sfx_req(sfx_req),
      .pause(pause),
      .note_change(note_change),
      .rom_addr(rom_addr),
      .rom_data(rom_data),
      .dur(dur),
      .tone(tone),
      .note_load(note_load),
      .active_song(active_song),
      .busy(busy),
      .sfx_done(sfx_done)
   );

   always #5 clk = ~clk;

   // Song ROM with one cycle of read latency.
   always @(posedge clk) rom_data <= rom[rom_addr];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Waits for the note at address a to load, checks it, and optionally ends it.
   task automatic play_note(input int a, input bit pulse, input bit done);
      int n = 0;
      int extra = 0;
      while (note_load !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      chk("note_load_seen", note_load, 1);
      chk("rom_addr", rom_addr, a);
      chk("tone", tone, rom[a][3:0]);
      chk("dur", dur, rom[a][7:4]);
      if (pulse) begin
         repeat ($urandom_range(1, 6)) begin
            step();
            if (note_load) extra++;
         end
         chk("single_load", extra, 0);
         note_change = 1'b1;
         step();
         note_change = 1'b0;
         chk("sfx_done", sfx_done, done);
         if (done) chk("tone_after_done", tone, 0);
      end
   endtask

   task automatic play_song(input int s, input int from);
      for (int a = from; a <= s_end[s]; a++) play_note(a, 1'b1, s != 0 && a == s_end[s]);
   endtask

   task automatic pulse_req(input logic [2:0] r);
      sfx_req = r;
      step();
      sfx_req = '0;
   endtask

   initial begin
      int tz, az, nl;
      for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
      rst = 1'b1;
      music_en = 1'b0;
      sfx_req = '0;
      pause = 1'b0;
      note_change = 1'b0;
      step();
      step();
      chk("rst_rom_addr", rom_addr, 0);
      chk("rst_tone", tone, 0);
      chk("rst_dur", dur, 0);
      chk("rst_busy", busy, 0);
      chk("rst_note_load", note_load, 0);
      chk("rst_sfx_done", sfx_done, 0);
      chk("rst_active", active_song, 0);
      rst = 1'b0;
      repeat (3) step();
      chk("idle_no_music", busy, 0);

      // Background loop: full pass, wrap, then stop on a random note k.
      music_en = 1'b1;
      k = $urandom_range(3, 15);
      play_song(0, 0);
      for (int a = 0; a < k; a++) play_note(a, 1'b1, 1'b0);
      play_note(k, 1'b0, 1'b0);

      // Effect interrupts song 0, which then resumes on the interrupted note.
      pulse_req(3'b001);
      step();
      chk("preempt_addr", rom_addr, 21);
      chk("preempt_active", active_song, 1);
      play_song(1, 21);
      play_note(k, 1'b0, 1'b0);
      chk("resume_active", active_song, 0);

      // Two simultaneous requests: higher first, lower next, then background.
      pulse_req(3'b011);
      step();
      chk("multi_addr", rom_addr, 28);
      play_song(2, 28);
      play_song(1, 21);
      play_note(k, 1'b0, 1'b0);

      // Pause freezes the note and silences; release replays it.
      pause = 1'b1;
      step();
      tz = 0; az = 0; nl = 0;
      for (int i = 0; i < 50; i++) begin
         note_change = (i % 10 == 5);
         step();
         note_change = 1'b0;
         if (tone !== 4'd0) tz++;
         if (rom_addr !== 8'(k)) az++;
         if (note_load) nl++;
      end
      chk("pause_tone_silent", tz, 0);
      chk("pause_addr_frozen", az, 0);
      chk("pause_no_load", nl, 0);
      chk("pause_busy", busy, 1);
      pause = 1'b0;
      play_note(k, 1'b0, 1'b0);

      // Music disable returns to idle and restarts song 0 from its start.
      music_en = 1'b0;
      step();
      chk("music_off_busy", busy, 0);
      chk("music_off_tone", tone, 0);
      music_en = 1'b1;
      play_note(0, 1'b1, 1'b0);
      play_note(1, 1'b0, 1'b0);

      // Same-song restart, then preemption coinciding with note_change.
      pulse_req(3'b001);
      play_note(21, 1'b1, 1'b0);
      play_note(22, 1'b0, 1'b0);
      pulse_req(3'b001);
      step();
      chk("restart_addr", rom_addr, 21);
      play_note(21, 1'b0, 1'b0);
      pulse_req(3'b100);
      note_change = 1'b1;
      step();
      note_change = 1'b0;
      chk("coincide_addr", rom_addr, 34);
      chk("coincide_no_done", sfx_done, 0);
      chk("coincide_active", active_song, 3);
      play_song(3, 34);
      play_note(1, 1'b0, 1'b0);
      chk("no_song1_resume", active_song, 0);

      // Reset in the middle of an effect with a lower request pending.
      pulse_req(3'b010);
      play_note(28, 1'b1, 1'b0);
      play_note(29, 1'b0, 1'b0);
      pulse_req(3'b001);
      step();
      rst = 1'b1;
      music_en = 1'b0;
      step();
      chk("midrst_tone", tone, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_addr", rom_addr, 0);
      chk("midrst_active", active_song, 0);
      rst = 1'b0;
      repeat (6) step();
      chk("midrst_pending_clear", busy, 0);
      music_en = 1'b1;
      play_note(0, 1'b1, 1'b0);
      play_note(1, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/song_scheduler.md
Name: song_scheduler

Overview:
- Sequences the shared song ROM, music_timer and tone_generator between one looping background song (song 0) and NUM_SONGS-1 one-shot sound effects (songs 1..N-1).
- Sits between game logic (music enable, effect request pulses) and the audio datapath.
- Owns the ROM address, latches each entry's duration/tone and restarts the timer per note.
- Fixed priority: a higher song index preempts a lower one immediately; background music resumes at the interrupted note.

Parameters:
- NUM_SONGS, 4, total songs including background song 0; max 16.
- ADDR_W, 8, song ROM address width.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- music_en  in  1  level; 1 = background song 0 plays when no effect is active.
- sfx_req  in  NUM_SONGS-1  one-cycle request pulses; bit k requests song k+1.
- pause  in  1  level; freezes sequencing and silences output.
- note_change  in  1  end-of-note pulse from music_timer.
- rom_addr  out  ADDR_W  registered song ROM address.
- rom_data  in  8  ROM output, valid 1 cycle after rom_addr; [7:4] duration, [3:0] tone.
- dur  out  4  registered duration to music_timer.
- tone  out  4  registered tone to tone_generator; 0 = silence.
- note_load  out  1  one-cycle pulse that restarts music_timer with the new dur.
- active_song  out  clog2(NUM_SONGS)  song currently sequenced.
- busy  out  1  high in any state except IDLE.
- sfx_done  out  1  one-cycle pulse when an effect plays its last note to completion.

Behaviour:
- Reset values:
  - rom_addr = SONG_START[0]; dur = 0; tone = 0; note_load = 0; active_song = 0; busy = 0; sfx_done = 0.
  - pending = 0; resume_addr = SONG_START[0]; state = IDLE.
- Pending: sfx_req bit k sets pending[k+1], which is sticky until song k+1 starts. Multiple simultaneous bits are all latched.
- Selection: the highest pending index wins. With nothing pending, song 0 is selected only if music_en = 1.
- FSM states: IDLE, FETCH, LATCH, PLAY, HOLD.
- IDLE:
  - tone = 0.
  - If a selection exists, load rom_addr (SONG_START[sel], or resume_addr for song 0), set active_song, clear that pending bit and go to FETCH.
- FETCH: one cycle, waiting on ROM latency; go to LATCH.
- LATCH:
  - Register dur/tone from rom_data and pulse note_load in the following cycle.
  - Go to PLAY.
  - Latency from request pulse to note_load is 4 cycles when idle: req at cycle t, pending at t+1, FETCH at t+2, LATCH at t+3, note_load at t+4.
- PLAY, on note_change:
  - If rom_addr != SONG_END[active]: increment rom_addr and go to FETCH.
  - Else, if song 0: wrap rom_addr to SONG_START[0] and go to FETCH.
  - Else (effect): pulse sfx_done, set tone = 0 and go to IDLE.
- Preemption:
  - Applies in FETCH, LATCH or PLAY when a pending index exceeds active_song.
  - If active = 0, save resume_addr = rom_addr, which replays the interrupted note.
  - Then jump to the new song's start and go to FETCH. No sfx_done for an aborted effect.
- Same-cycle preemption and note_change: preemption wins. The saved address is the current note, not the next.
- Same-song request: a request for the currently active effect restarts it from SONG_START.
- Lower-priority request during an effect: stays pending and plays after the effect, ahead of song 0.
- music_en = 0 while song 0 plays: next cycle go to IDLE, tone = 0, resume_addr = SONG_START[0].
- Pause:
  - pause = 1 in PLAY moves to HOLD: tone = 0 and note_change is ignored.
  - pause = 0 returns to LATCH, which re-registers the current entry and pulses note_load so the note restarts.
  - Pending requests accumulate during HOLD.
- rst mid-song: all state cleared per reset values; output is silent the next cycle.
- rom_addr arithmetic is ADDR_W wide. Song table bounds guarantee the increment never wraps.

Decomposition:
- Package song_pkg holds:
  - SONG_START / SONG_END constant arrays: song 0 0..20, song 1 21..27, song 2 28..33, song 3 34..39.
  - TONE_REST = 0.
  - The FSM state enum.
- Sub-module song_req_arbiter (combinational): pending + music_en + active_song → sel index, sel_valid, preempt.

Test Plan:
- Reset, music_en=1, note_change every 10 cycles → rom_addr steps 0..20 then 0; note_load once per note; tone equals ROM nibble.
- Song 0 at addr 7, pulse sfx_req[0] → rom_addr = 21 within 2 cycles; after addr 27 note_change → sfx_done pulse; song 0 resumes at addr 7.
- sfx_req = 3'b011 in one cycle → song 2 (28..33) plays, then song 1 (21..27), then song 0.
- pause=1 during PLAY for 50 cycles with note_change pulses → tone = 0, rom_addr frozen; pause=0 → note_load pulse, same tone restored.
- Song 1 active, sfx_req[2] coinciding with note_change → rom_addr = 34, no sfx_done, song 1 not resumed.
- rst asserted mid-effect → next cycle tone = 0, busy = 0, rom_addr = 0, pending cleared.
